// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter: accepts a WIDTH-bit word over valid/ready and
// presents it one bit per enabled cycle on sout, with back-to-back reload.
module piso_stream #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n, shifted;
    logic [CW-1:0]    cnt, cnt_n;
    logic             sout_n, sout_valid_n, frame_start_n, done_n;
    logic             last_bit, accept;

    // Bit on the wire is always the leading end of the register for the chosen order.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            sout        <= IDLE_LEVEL;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            cnt         <= cnt_n;
            sout        <= sout_n;
            sout_valid  <= sout_valid_n;
            frame_start <= frame_start_n;
            done        <= done_n;
        end
    end

    // Handshake: a word transfers on a cycle where in_valid & in_ready are both high.
    // in_ready is high in IDLE and on the cycle the last bit of a frame is consumed.
    always_comb begin
        state_n       = state;
        shreg_n       = shreg;
        cnt_n         = cnt;
        sout_n        = sout;
        sout_valid_n  = sout_valid;
        frame_start_n = frame_start;
        done_n        = 1'b0;
        in_ready      = 1'b0;
        shifted       = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
        last_bit      = (state == SHIFT) && shift_en && (cnt == LAST_CNT);
        accept        = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                if (shift_en) begin
                    if (last_bit) begin
                        in_ready      = 1'b1;
                        done_n        = 1'b1;
                        state_n       = IDLE;
                        shreg_n       = '0;
                        cnt_n         = '0;
                        sout_n        = IDLE_LEVEL;
                        sout_valid_n  = 1'b0;
                        frame_start_n = 1'b0;
                    end else begin
                        shreg_n       = shifted;
                        sout_n        = lead_bit(shifted);
                        cnt_n         = cnt + CW'(1);
                        frame_start_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        accept = in_valid && in_ready;
        // A load overrides the idle transition so reloads leave no gap.
        if (accept) begin
            state_n       = SHIFT;
            shreg_n       = in_data;
            cnt_n         = '0;
            sout_n        = lead_bit(in_data);
            sout_valid_n  = 1'b1;
            frame_start_n = 1'b1;
        end
    end

    assign busy = sout_valid;

endmodule
